// File: rtl/except_ctrl_pkg.sv
// Shared CP0/exception definitions: exception codes, CP0 register addresses,
// exception-controller state encoding and the latched exception record.
package except_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  // Cause bits software may write: IP1..IP0 (9:8), WP (22), IV (23).
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00C0_0300;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic        dslot;
    logic [31:0] new_pc;
  } exc_rec_t;

endpackage

// File: rtl/except_ctrl_cp0_fwd.sv
// CP0 read-value forwarding from a same-cycle WB mtc0; shared with the EX mfc0 path.
module cp0_fwd
  import except_ctrl_pkg::*;
(
  input  logic [31:0] i_status,
  input  logic [31:0] i_cause,
  input  logic [31:0] i_epc,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_status,
  output logic [31:0] o_cause,
  output logic [31:0] o_epc
);

  logic w_wr_status;
  logic w_wr_cause;
  logic w_wr_epc;

  assign w_wr_status = i_we && (i_waddr == CP0_REG_STATUS);
  assign w_wr_cause  = i_we && (i_waddr == CP0_REG_CAUSE);
  assign w_wr_epc    = i_we && (i_waddr == CP0_REG_EPC);

  assign o_status = w_wr_status ? i_wdata : i_status;
  assign o_epc    = w_wr_epc    ? i_wdata : i_epc;
  // Only the software-writable Cause bits come from WB; the rest are hardware-owned.
  assign o_cause  = w_wr_cause ? ((i_cause & ~CAUSE_WR_MASK) | (i_wdata & CAUSE_WR_MASK))
                               : i_cause;

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: prioritises exceptions/interrupts, holds them
// across stalls and issues a one-cycle flush with the redirect PC into CP0.
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exc_flags_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic        stall_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] exc_inst_addr_o,
  output logic        exc_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] epc_o
);

  exc_state_e  r_state;
  exc_state_e  w_next;
  exc_rec_t    r_rec;
  exc_rec_t    w_rec;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic [31:0] w_code;
  logic        w_int;
  logic        w_detect;
  logic        w_unused;

  cp0_fwd u_cp0_fwd (
    .i_status (cp0_status_i),
    .i_cause  (cp0_cause_i),
    .i_epc    (cp0_epc_i),
    .i_we     (wb_cp0_we_i),
    .i_waddr  (wb_cp0_waddr_i),
    .i_wdata  (wb_cp0_data_i),
    .o_status (w_status),
    .o_cause  (w_cause),
    .o_epc    (epc_o)
  );

  assign w_int = (|(w_cause[15:8] & w_status[15:8])) && !w_status[1] && w_status[0];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_code = '0;
    if (|inst_addr_i) begin
      if (w_int)                w_code = EXC_INT;
      else if (exc_flags_i[8])  w_code = EXC_SYS;
      else if (exc_flags_i[9])  w_code = EXC_RI;
      else if (exc_flags_i[10]) w_code = EXC_TR;
      else if (exc_flags_i[11]) w_code = EXC_OV;
      else if (exc_flags_i[12]) w_code = EXC_ERET;
    end
  end

  assign w_detect = |w_code;

  always_comb begin
    w_rec.code   = w_code;
    w_rec.pc     = inst_addr_i;
    w_rec.dslot  = in_delayslot_i;
    w_rec.new_pc = (w_code == EXC_ERET) ? epc_o : HANDLER_ADDR;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_detect) w_next = stall_i ? HOLD : FLUSH;
      HOLD:    if (!stall_i) w_next = FLUSH;
      FLUSH:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // NOTE: the record is reset too, so a HOLD/FLUSH interrupted by reset can never leak out.
  always_ff @(posedge clk) begin
    if (rst)                            r_rec <= '0;
    else if (r_state == IDLE && w_detect) r_rec <= w_rec;
  end

  always_comb begin
    excepttype_o    = '0;
    exc_inst_addr_o = '0;
    exc_delayslot_o = 1'b0;
    flush_o         = 1'b0;
    new_pc_o        = '0;
    if (r_state == FLUSH) begin
      excepttype_o    = r_rec.code;
      exc_inst_addr_o = r_rec.pc;
      exc_delayslot_o = r_rec.dslot;
      flush_o         = 1'b1;
      new_pc_o        = r_rec.new_pc;
    end
  end

  assign w_unused = ^{exc_flags_i[31:13], exc_flags_i[7:0], w_status[31:16],
                      w_status[7:2], w_cause[31:16], w_cause[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed vector table, hand-written
// stall/reset sequences and randomized traffic against a behavioural model.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] exc_flags;
  logic [31:0] inst_addr;
  logic        in_ds;
  logic        stall;
  logic [31:0] status, cause, epc;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] excepttype_o, exc_inst_addr_o, new_pc_o, epc_o;
  logic        exc_delayslot_o, flush_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  except_ctrl #(.HANDLER_ADDR(32'h20)) dut (
    .clk             (clk),
    .rst             (rst),
    .exc_flags_i     (exc_flags),
    .inst_addr_i     (inst_addr),
    .in_delayslot_i  (in_ds),
    .stall_i         (stall),
    .cp0_status_i    (status),
    .cp0_cause_i     (cause),
    .cp0_epc_i       (epc),
    .wb_cp0_we_i     (we),
    .wb_cp0_waddr_i  (waddr),
    .wb_cp0_data_i   (wdata),
    .excepttype_o    (excepttype_o),
    .exc_inst_addr_o (exc_inst_addr_o),
    .exc_delayslot_o (exc_delayslot_o),
    .flush_o         (flush_o),
    .new_pc_o        (new_pc_o),
    .epc_o           (epc_o)
  );

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic        flush;
    logic [31:0] new_pc;
  } exp_t;

  // Model: at most one exception outstanding; accepted only when nothing is
  // pending or being issued, and issued the cycle after the first unstalled cycle.
  logic pend_v = 1'b0;
  exp_t pend, exp_now, exp_nxt, zero_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_epc();
    return (we && waddr == 5'd14) ? wdata : epc;
  endfunction

  function automatic logic [31:0] m_code();
    logic [31:0] st, ca;
    st = (we && waddr == 5'd12) ? wdata : status;
    ca = cause;
    if (we && waddr == 5'd13) begin
      ca[9:8] = wdata[9:8];
      ca[22]  = wdata[22];
      ca[23]  = wdata[23];
    end
    if (inst_addr == 0) return 0;
    if ((ca[15:8] & st[15:8]) != 0 && st[1] == 1'b0 && st[0] == 1'b1) return 32'h1;
    if (exc_flags[8])  return 32'h8;
    if (exc_flags[9])  return 32'ha;
    if (exc_flags[10]) return 32'hd;
    if (exc_flags[11]) return 32'hc;
    if (exc_flags[12]) return 32'he;
    return 0;
  endfunction

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    logic [31:0] c;
    #1;
    check("epc_o", epc_o, m_epc());
    exp_nxt = zero_exp;
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (!pend_v && !exp_now.flush) begin
        c = m_code();
        if (c != 0) begin
          pend_v      = 1'b1;
          pend.code   = c;
          pend.pc     = inst_addr;
          pend.ds     = in_ds;
          pend.flush  = 1'b1;
          pend.new_pc = (c == 32'he) ? m_epc() : 32'h20;
        end
      end
      if (pend_v && !stall) begin
        exp_nxt = pend;
        pend_v  = 1'b0;
      end
    end
    @(negedge clk);
    check("excepttype_o", excepttype_o, exp_nxt.code);
    check("exc_inst_addr_o", exc_inst_addr_o, exp_nxt.pc);
    check("exc_delayslot_o", {31'b0, exc_delayslot_o}, {31'b0, exp_nxt.ds});
    check("flush_o", {31'b0, flush_o}, {31'b0, exp_nxt.flush});
    check("new_pc_o", new_pc_o, exp_nxt.new_pc);
    exp_now = exp_nxt;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; exc_flags = '0; inst_addr = '0; in_ds = 1'b0; stall = 1'b0;
    status = '0; cause = '0; epc = '0; we = 1'b0; waddr = '0; wdata = '0;
  endtask

  typedef struct {
    logic [31:0] flags, addr;
    logic        ds;
    logic [31:0] status, cause, epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] exp_code, exp_new_pc;
  } vec_t;

  function automatic vec_t mk(logic [31:0] flags, logic [31:0] addr, logic ds,
                              logic [31:0] st, logic [31:0] ca, logic [31:0] ep,
                              logic w, logic [4:0] wa, logic [31:0] wd,
                              logic [31:0] ec, logic [31:0] enp);
    vec_t v;
    v.flags = flags; v.addr = addr; v.ds = ds; v.status = st; v.cause = ca; v.epc = ep;
    v.we = w; v.waddr = wa; v.wdata = wd; v.exp_code = ec; v.exp_new_pc = enp;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    zero_exp = '{code: 0, pc: 0, ds: 0, flush: 0, new_pc: 0};
    exp_now  = zero_exp;
    pend     = zero_exp;

    tbl[0]  = mk(32'h0100, 32'h80, 0, 0,        0,       0,      0, 0,  0,          32'h8, 32'h20);
    tbl[1]  = mk(32'h1000, 32'h84, 0, 0,        0,       32'h100, 1, 14, 32'h200,   32'he, 32'h200);
    tbl[2]  = mk(32'h0000, 32'h40, 0, 32'hFF01, 32'h0400, 0,      0, 0,  0,          32'h1, 32'h20);
    tbl[3]  = mk(32'h0000, 32'h40, 0, 32'hFF03, 32'h0400, 0,      0, 0,  0,          32'h0, 32'h0);
    tbl[4]  = mk(32'h0000, 32'h00, 0, 32'hFF01, 32'h0400, 0,      0, 0,  0,          32'h0, 32'h0);
    tbl[5]  = mk(32'h0900, 32'h48, 0, 32'hFF01, 32'h0400, 0,      0, 0,  0,          32'h1, 32'h20);
    tbl[6]  = mk(32'h0900, 32'h48, 0, 0,        0,       0,      0, 0,  0,          32'h8, 32'h20);
    tbl[7]  = mk(32'h0200, 32'h4c, 0, 0,        0,       0,      0, 0,  0,          32'ha, 32'h20);
    tbl[8]  = mk(32'h0400, 32'h50, 1, 0,        0,       0,      0, 0,  0,          32'hd, 32'h20);
    tbl[9]  = mk(32'h0800, 32'h54, 0, 0,        0,       0,      0, 0,  0,          32'hc, 32'h20);
    tbl[10] = mk(32'h0000, 32'h58, 0, 0,        32'h0400, 0,      1, 12, 32'hFF01,   32'h1, 32'h20);
    tbl[11] = mk(32'h0000, 32'h5c, 0, 32'hFF01, 0,       0,      1, 13, 32'h0400,   32'h0, 32'h0);
    tbl[12] = mk(32'h0000, 32'h5c, 0, 32'h0101, 0,       0,      1, 13, 32'h0100,   32'h1, 32'h20);
    tbl[13] = mk(32'h2000, 32'h60, 0, 0,        0,       0,      0, 0,  0,          32'h0, 32'h0);
    tbl[14] = mk(32'h1000, 32'h90, 1, 0,        0,       32'h300, 0, 0,  0,          32'he, 32'h300);

    // Reset
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    check("reset flush_o", {31'b0, flush_o}, 32'h0);
    rst = 1'b0;
    cycle();

    // Directed table: one instruction, then a bubble while the flush (if any) is out.
    for (int i = 0; i < 15; i++) begin
      idle_inputs();
      exc_flags = tbl[i].flags; inst_addr = tbl[i].addr; in_ds = tbl[i].ds;
      status = tbl[i].status; cause = tbl[i].cause; epc = tbl[i].epc;
      we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
      cycle();
      check($sformatf("tbl%0d code", i), excepttype_o, tbl[i].exp_code);
      check($sformatf("tbl%0d new_pc", i), new_pc_o, tbl[i].exp_new_pc);
      check($sformatf("tbl%0d flush", i), {31'b0, flush_o}, {31'b0, tbl[i].exp_code != 0});
      check($sformatf("tbl%0d pc", i), exc_inst_addr_o, (tbl[i].exp_code != 0) ? tbl[i].addr : 32'h0);
      idle_inputs();
      cycle();
      check($sformatf("tbl%0d pulse end", i), {31'b0, flush_o}, 32'h0);
    end

    // Stall hold: overflow at 0x60, stalled 3 cycles with changing inputs.
    idle_inputs();
    exc_flags = 32'h0800; inst_addr = 32'h60; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("stall no flush", {31'b0, flush_o}, 32'h0);
      exc_flags = 32'h0100; inst_addr = 32'h70 + 32'(k); in_ds = 1'b1;
    end
    stall = 1'b0; exc_flags = '0; inst_addr = '0; in_ds = 1'b0;
    cycle();
    check("stall release code", excepttype_o, 32'hc);
    check("stall release pc", exc_inst_addr_o, 32'h60);
    check("stall release flush", {31'b0, flush_o}, 32'h1);
    cycle();
    check("stall single pulse", {31'b0, flush_o}, 32'h0);

    // Reset while holding: nothing may be issued afterwards.
    idle_inputs();
    exc_flags = 32'h0100; inst_addr = 32'h80; stall = 1'b1;
    cycle();
    exc_flags = '0; inst_addr = '0;
    rst = 1'b1;
    cycle();
    check("hold reset code", excepttype_o, 32'h0);
    check("hold reset flush", {31'b0, flush_o}, 32'h0);
    rst = 1'b0; stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("post reset no flush", {31'b0, flush_o}, 32'h0);
    end

    // Back-to-back: persistent syscall gives a pulse every other cycle.
    idle_inputs();
    exc_flags = 32'h0100; inst_addr = 32'h80;
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("b2b alternate", {31'b0, flush_o}, {31'b0, (k % 2) == 0});
    end
    idle_inputs();
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] addrs [4];
      addrs = '{5'd12, 5'd13, 5'd14, 5'($urandom_range(0, 31))};
      rst       = ($urandom_range(0, 99) == 0);
      exc_flags = ($urandom_range(0, 2) == 0) ? $urandom : ($urandom & 32'h1F00);
      if ($urandom_range(0, 2) == 0) exc_flags = '0;
      inst_addr = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      in_ds     = 1'($urandom);
      stall     = ($urandom_range(0, 2) == 0);
      status    = $urandom & 32'hFFFF_FF03;
      if ($urandom_range(0, 1) == 0) status[1:0] = 2'b01;
      cause     = ($urandom_range(0, 1) == 0) ? $urandom : 32'h0;
      epc       = $urandom;
      we        = ($urandom_range(0, 2) == 0);
      waddr     = addrs[$urandom_range(0, 3)];
      wdata     = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
